// File: rtl/ov7670_capture.sv
`default_nettype none
// ============================================================================
//  Module   : ov7670_capture
//  Purpose  : OV7670 RGB565 byte-stream capture, packed to RGB332 with a
//             linear frame-buffer write address and end-of-frame pulse.
//             Optional macro CAPTURE_TEST_PATTERN_EN replaces camera pixels
//             with horizontal red/green/blue bars.
//  Revision : 1.0  initial release
// ============================================================================
module ov7670_capture #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ADDR_WIDTH    = 15,
    parameter int BAR_HEIGHT    = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_vsync,
    input  logic                  i_href,
    input  logic [7:0]            i_data,
    output logic [7:0]            o_pixel,
    output logic [ADDR_WIDTH-1:0] o_write_address,
    output logic                  o_write_en,
    output logic                  o_frame_done,
    output logic [7:0]            o_frame_count
);

    localparam int c_COL_W = $clog2(SCREEN_WIDTH + 1);
    localparam int c_ROW_W = $clog2(SCREEN_HEIGHT + 1);
    localparam logic [c_COL_W-1:0]    c_COL_MAX     = c_COL_W'(SCREEN_WIDTH);
    localparam logic [c_ROW_W-1:0]    c_ROW_MAX     = c_ROW_W'(SCREEN_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] c_LINE_STRIDE = ADDR_WIDTH'(SCREEN_WIDTH);

    typedef enum logic [1:0] {
        ST_WAIT_VS = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                  r_vsync;
    logic                  r_vsync_d;
    logic                  r_href;
    logic                  r_href_d;
    logic [7:0]            r_data;
    logic [5:0]            r_byte1;
    logic                  r_phase;
    logic [c_COL_W-1:0]    r_col;
    logic [c_ROW_W-1:0]    r_row;

    logic                  w_vs_rise;
    logic                  w_vs_fall;
    logic                  w_href_fall;
    logic                  w_start;
    logic                  w_frame_end;
    logic                  w_take_byte;
    logic                  w_line_end;
    logic                  w_in_window;
    logic [7:0]            w_pixel;
    logic [ADDR_WIDTH-1:0] w_addr;

    // Input stage; edges are taken between the registered copy and its delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync   <= 1'b0;
            r_vsync_d <= 1'b0;
            r_href    <= 1'b0;
            r_href_d  <= 1'b0;
            r_data    <= 8'h00;
        end else begin
            r_vsync   <= i_vsync;
            r_vsync_d <= r_vsync;
            r_href    <= i_href;
            r_href_d  <= r_href;
            r_data    <= i_data;
        end
    end

    assign w_vs_rise   =  r_vsync & ~r_vsync_d;
    assign w_vs_fall   = ~r_vsync &  r_vsync_d;
    assign w_href_fall = ~r_href  &  r_href_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT_VS;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame end has priority over any byte or line event in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_frame_end  = 1'b0;
        w_take_byte  = 1'b0;
        w_line_end   = 1'b0;
        case (r_state)
            ST_WAIT_VS: begin
                if (r_vsync) w_state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_vs_fall) begin
                    w_state_next = ST_CAPTURE;
                    w_start      = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (w_vs_rise) begin
                    w_state_next = ST_WAIT_VS;
                    w_frame_end  = 1'b1;
                end else if (r_href) begin
                    w_take_byte  = 1'b1;
                end else if (w_href_fall) begin
                    w_line_end   = 1'b1;
                end
            end
            default: w_state_next = ST_WAIT_VS;
        endcase
    end

    assign w_in_window = (r_col < c_COL_MAX) && (r_row < c_ROW_MAX);
    assign w_addr      = ADDR_WIDTH'(r_row) * c_LINE_STRIDE + ADDR_WIDTH'(r_col);

`ifdef CAPTURE_TEST_PATTERN_EN
    logic [c_ROW_W-1:0] w_bar_sel;
    always_comb begin
        w_bar_sel = (r_row / c_ROW_W'(BAR_HEIGHT)) % c_ROW_W'(3);
        if (w_bar_sel == c_ROW_W'(0)) begin
            w_pixel = 8'hE0;
        end else if (w_bar_sel == c_ROW_W'(1)) begin
            w_pixel = 8'h1C;
        end else begin
            w_pixel = 8'h03;
        end
    end
`else
    assign w_pixel = {r_byte1, r_data[4:3]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte1         <= 6'd0;
            r_phase         <= 1'b0;
            r_col           <= '0;
            r_row           <= '0;
            o_pixel         <= 8'h00;
            o_write_address <= '0;
            o_write_en      <= 1'b0;
            o_frame_done    <= 1'b0;
            o_frame_count   <= 8'h00;
        end else begin
            o_write_en   <= 1'b0;
            o_frame_done <= 1'b0;
            if (w_start) begin
                r_col   <= '0;
                r_row   <= '0;
                r_phase <= 1'b0;
            end else if (w_frame_end) begin
                o_frame_done  <= 1'b1;
                o_frame_count <= o_frame_count + 8'd1;
                r_phase       <= 1'b0;
            end else if (w_take_byte) begin
                if (!r_phase) begin
                    r_byte1 <= {r_data[7:5], r_data[2:0]};
                    r_phase <= 1'b1;
                end else begin
                    r_phase <= 1'b0;
                    if (w_in_window) begin
                        o_write_en      <= 1'b1;
                        o_pixel         <= w_pixel;
                        o_write_address <= w_addr;
                    end
                    // Column saturates so oversize lines never wrap the address.
                    if (r_col < c_COL_MAX) r_col <= r_col + 1'b1;
                end
            end else if (w_line_end) begin
                if ((r_col != '0) && (r_row < c_ROW_MAX)) r_row <= r_row + 1'b1;
                r_col   <= '0;
                r_phase <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
